// File: rtl/issue_scheduler.sv
// -----------------------------------------------------------------------------
// issue_scheduler
//
// In-order issue scheduler between decode and the execution units. Keeps a
// 64-entry register scoreboard and decides, each cycle, whether the
// instruction held in the decode output registers may issue. Checks RAW and
// WAW hazards, execution-unit availability and branch serialisation, and
// drives stall back into decode so decode holds its outputs until issue.
//
// Optional feature macro:
//   ISSUE_SCHED_WB_BYPASS_EN - when defined, writebacks of the current cycle
//                              are applied to the scoreboard before the hazard
//                              check, so a waiting consumer issues in the same
//                              cycle as its writeback. When undefined the
//                              hazard check uses the registered scoreboard only
//                              (no wb -> issue combinational path, one extra
//                              stall cycle per dependency).
//
// Parameters:
//   NUM_UNITS  number of execution units (3-bit unit field, default 8)
//   CNT_W      width of the stall performance counter
//
// Ports:
//   clk                     clock
//   rst                     synchronous active-high reset
//   dec_valid               decode outputs hold a real instruction
//   unit[2:0]               target execution unit
//   r1_rn, r2_rn[5:0]       source registers, 0 = no operand
//   rd_rn, rd2_rn[5:0]      destination registers, 0 = no write
//   unit_ready[NUM_UNITS]   unit i can accept an instruction this cycle
//   wb0_valid, wb0_rn       writeback port 0
//   wb1_valid, wb1_rn       writeback port 1
//   br_done                 unit 7 resolved the outstanding branch/jump
//   issue                   instruction dispatched this cycle
//   issue_unit[NUM_UNITS]   one-hot of unit when issue is high, else 0
//   stall                   decode must hold its outputs
//   busy_regs[63:0]         registered scoreboard contents
//   stall_cnt[CNT_W]        number of cycles with stall high (wrapping)
//
// State table:
//   state   | meaning
//   RUN     | normal operation, instructions may issue
//   BR_WAIT | a branch/jump is outstanding on unit 7; nothing issues until
//           | br_done, and the first issue after it happens a cycle later
// -----------------------------------------------------------------------------
module issue_scheduler #(
    parameter int NUM_UNITS = 8,
    parameter int CNT_W     = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 dec_valid,
    input  logic [2:0]           unit,
    input  logic [5:0]           r1_rn,
    input  logic [5:0]           r2_rn,
    input  logic [5:0]           rd_rn,
    input  logic [5:0]           rd2_rn,
    input  logic [NUM_UNITS-1:0] unit_ready,
    input  logic                 wb0_valid,
    input  logic [5:0]           wb0_rn,
    input  logic                 wb1_valid,
    input  logic [5:0]           wb1_rn,
    input  logic                 br_done,
    output logic                 issue,
    output logic [NUM_UNITS-1:0] issue_unit,
    output logic                 stall,
    output logic [63:0]          busy_regs,
    output logic [CNT_W-1:0]     stall_cnt
);

    localparam logic [2:0] BR_UNIT = 3'd7;

    typedef enum logic {
        RUN,
        BR_WAIT
    } state_t;

    state_t                 state;
    state_t                 state_nxt;

    logic [63:0]            busy;
    logic [63:0]            busy_nxt;
    logic [63:0]            busy_eff;
    logic [63:0]            wb_clr;
    logic [63:0]            set_mask;
    logic                   hazard;
    logic                   unit_ok;
    logic [NUM_UNITS-1:0]   unit_onehot;

    // Decode a register number into a scoreboard mask; register 0 never maps
    // to a bit so it can neither be set nor cause a hazard.
    function automatic logic [63:0] reg_bit(input logic [5:0] rn);
        logic [63:0] m;
        m = 64'd0;
        if (rn != 6'd0) begin
            m[rn] = 1'b1;
        end
        return m;
    endfunction

    // Both ports targeting the same register simply OR into one clear.
    always_comb begin
        wb_clr = 64'd0;
        if (wb0_valid) begin
            wb_clr = wb_clr | reg_bit(wb0_rn);
        end
        if (wb1_valid) begin
            wb_clr = wb_clr | reg_bit(wb1_rn);
        end
    end

`ifdef ISSUE_SCHED_WB_BYPASS_EN
    always_comb busy_eff = busy & ~wb_clr;
`else
    always_comb busy_eff = busy;
`endif

    always_comb begin
        hazard = ((r1_rn  != 6'd0) && busy_eff[r1_rn])
              || ((r2_rn  != 6'd0) && busy_eff[r2_rn])
              || ((rd_rn  != 6'd0) && busy_eff[rd_rn])
              || ((rd2_rn != 6'd0) && busy_eff[rd2_rn]);
    end

    // A unit number beyond NUM_UNITS decodes to an all-zero one-hot and
    // therefore never reports ready.
    always_comb begin
        unit_onehot = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            unit_onehot[i] = (int'(unit) == i);
        end
        unit_ok = |(unit_onehot & unit_ready);
    end

    // ---------------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------------------------------------------------------------
    // FSM: next state and issue decision
    // br_done only feeds state_nxt, keeping it off the issue/stall paths.
    // ---------------------------------------------------------------------
    always_comb begin
        state_nxt  = state;
        issue      = 1'b0;
        case (state)
            RUN: begin
                issue = dec_valid & ~hazard & unit_ok;
                if (issue && (unit == BR_UNIT)) begin
                    state_nxt = BR_WAIT;
                end
            end
            BR_WAIT: begin
                if (br_done) begin
                    state_nxt = RUN;
                end
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
        stall      = dec_valid & ~issue;
        issue_unit = issue ? unit_onehot : '0;
    end

    // ---------------------------------------------------------------------
    // Scoreboard: sets are applied after clears so that a same-cycle set and
    // clear of one register leaves it busy.
    // ---------------------------------------------------------------------
    always_comb begin
        set_mask = 64'd0;
        if (issue) begin
            set_mask = reg_bit(rd_rn) | reg_bit(rd2_rn);
        end
        busy_nxt = (busy & ~wb_clr) | set_mask;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 64'd0;
        end else begin
            busy <= busy_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign busy_regs = busy;

endmodule
